// File: rtl/result_serializer.sv
// Splits each 144-bit systolic-array result into three 48-bit AXI-Stream beats
// and frames MATS_PER_PKT matrices per packet with m_axis_last.
module result_serializer #(
  parameter int unsigned MATS_PER_PKT = 1
) (
  input  logic         axi_clk,
  input  logic         axi_resetn,
  input  logic         s_axis_valid,
  input  logic [143:0] s_axis_data,
  output logic         s_axis_ready,
  output logic         m_axis_valid,
  output logic [47:0]  m_axis_data,
  output logic         m_axis_last,
  input  logic         m_axis_ready,
  output logic [15:0]  mat_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [15:0] LAST_MAT = 16'(MATS_PER_PKT - 1);

  state_t         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [15:0]    mat_q, mat_d;
  logic [143:0]   hold_q, hold_d;
  logic           final_beat;

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      mat_q   <= 16'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mat_q   <= mat_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    mat_d        = mat_q;
    hold_d       = hold_q;
    final_beat   = (state_q == SEND) && (beat_q == 2'd2);
    m_axis_valid = (state_q == SEND);
    m_axis_last  = final_beat && (mat_q == LAST_MAT);
    mat_count    = mat_q;
    // Ready is gated by reset so nothing is taken while the block is held.
    s_axis_ready = axi_resetn && ((state_q == IDLE) || (final_beat && m_axis_ready));

    case (beat_q)
      2'd0:    m_axis_data = hold_q[47:0];
      2'd1:    m_axis_data = hold_q[95:48];
      2'd2:    m_axis_data = hold_q[143:96];
      default: m_axis_data = '0;
    endcase

    case (state_q)
      IDLE: begin
        if (s_axis_valid) begin
          hold_d  = s_axis_data;
          beat_d  = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_axis_ready) begin
          if (beat_q == 2'd2) begin
            mat_d  = (mat_q == LAST_MAT) ? 16'd0 : mat_q + 16'd1;
            beat_d = 2'd0;
            // Zero-bubble reload: next word replaces hold only after beat 2 leaves.
            if (s_axis_valid) begin
              hold_d = s_axis_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: two instances (MATS_PER_PKT 1 and 3)
// share the same stimulus; vectors plus hand-built streaming/reset sequences.
module tb_result_serializer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         sv = 1'b0;
  logic [143:0] sd = '0;
  logic         mr = 1'b0;

  logic         sr1, mv1, l1, sr3, mv3, l3;
  logic [47:0]  md1, md3;
  logic [15:0]  mc1, mc3;

  int npass = 0;
  int ntot  = 0;
  int exp_m3 = 0;
  int lastpos[$];

  always #5 clk = ~clk;

  result_serializer #(.MATS_PER_PKT(1)) u_dut1 (
    .axi_clk(clk), .axi_resetn(rstn),
    .s_axis_valid(sv), .s_axis_data(sd), .s_axis_ready(sr1),
    .m_axis_valid(mv1), .m_axis_data(md1), .m_axis_last(l1),
    .m_axis_ready(mr), .mat_count(mc1)
  );

  result_serializer #(.MATS_PER_PKT(3)) u_dut3 (
    .axi_clk(clk), .axi_resetn(rstn),
    .s_axis_valid(sv), .s_axis_data(sd), .s_axis_ready(sr3),
    .m_axis_valid(mv3), .m_axis_data(md3), .m_axis_last(l3),
    .m_axis_ready(mr), .mat_count(mc3)
  );

  typedef struct {
    logic         sv;
    logic [143:0] sd;
    logic         mr;
    logic         sr;
    logic         mv;
    logic [47:0]  md;
    logic         l1;
    logic [15:0]  m1;
    logic         l3;
    logic [15:0]  m3;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [143:0] mkword(input logic [15:0] base);
    logic [143:0] w;
    for (int k = 0; k < 9; k++) w[16*k +: 16] = base + 16'(k);
    return w;
  endfunction

  function automatic logic [47:0] beatval(input logic [15:0] base, input int b);
    logic [15:0] e0;
    e0 = base + 16'(3 * b);
    return {e0 + 16'd2, e0 + 16'd1, e0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; sv = 1'b0; mr = 1'b1;
    @(negedge clk);
    chk("rst_sready1", 64'(sr1), 64'd0);
    chk("rst_sready3", 64'(sr3), 64'd0);
    tick;
    @(negedge clk);
    chk("rst_mvalid", 64'(mv1), 64'd0);
    chk("rst_mdata", 64'(md1), 64'd0);
    chk("rst_mlast3", 64'(l3), 64'd0);
    chk("rst_matcnt3", 64'(mc3), 64'd0);
    tick;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_sready", 64'(sr1), 64'd1);
    chk("post_rst_mvalid", 64'(mv1), 64'd0);
    tick;
    exp_m3 = 0;
  endtask

  // Streams n matrices back to back with both sides always ready.
  task automatic stream(input int n, input logic [15:0] base);
    int b, m;
    for (int cyc = 0; cyc <= 3 * n; cyc++) begin
      sv = (cyc <= 3 * (n - 1));
      sd = mkword(base + 16'(16 * ((cyc + 2) / 3)));
      mr = 1'b1;
      @(negedge clk);
      if (cyc < 3 * n) begin
        chk("str_sready1", 64'(sr1), 64'((cyc % 3) == 0));
        chk("str_sready3", 64'(sr3), 64'((cyc % 3) == 0));
      end
      b = (cyc + 2) % 3;
      m = (cyc - 1) / 3;
      if (cyc == 0) begin
        chk("str_idle_mvalid", 64'(mv1), 64'd0);
      end else begin
        chk("str_mvalid1", 64'(mv1), 64'd1);
        chk("str_mvalid3", 64'(mv3), 64'd1);
        chk("str_mdata1", 64'(md1), 64'(beatval(base + 16'(16 * m), b)));
        chk("str_mdata3", 64'(md3), 64'(beatval(base + 16'(16 * m), b)));
        chk("str_mlast1", 64'(l1), 64'(b == 2));
        chk("str_mlast3", 64'(l3), 64'(b == 2 && exp_m3 == 2));
        chk("str_matcnt1", 64'(mc1), 64'd0);
        chk("str_matcnt3", 64'(mc3), 64'(exp_m3));
        if (l3) lastpos.push_back(cyc);
      end
      tick;
      if (cyc >= 1 && b == 2) exp_m3 = (exp_m3 + 1) % 3;
    end
    sv = 1'b0;
    @(negedge clk);
    chk("str_end_mvalid", 64'(mv1), 64'd0);
    chk("str_end_matcnt3", 64'(mc3), 64'(exp_m3));
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [143:0] din, dx;
    logic [47:0]  b0, b1, b2;
    din = mkword(16'h0100);
    dx  = mkword(16'hE000);
    b0  = 48'h0102_0101_0100;
    b1  = 48'h0105_0104_0103;
    b2  = 48'h0108_0107_0106;

    // sv, sd, mr | sr, mv, md, l1, m1, l3, m3
    tbl[0]  = '{1'b1, din,  1'b1, 1'b1, 1'b0, 48'h0, 1'b0, 16'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, '0,   1'b1, 1'b0, 1'b1, b0,    1'b0, 16'd0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, '0,   1'b1, 1'b0, 1'b1, b1,    1'b0, 16'd0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, '0,   1'b1, 1'b1, 1'b1, b2,    1'b1, 16'd0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, din,  1'b1, 1'b1, 1'b0, 48'h0, 1'b0, 16'd0, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, dx,   1'b0, 1'b0, 1'b1, b0,    1'b0, 16'd0, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, dx,   1'b0, 1'b0, 1'b1, b0,    1'b0, 16'd0, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, dx,   1'b1, 1'b0, 1'b1, b0,    1'b0, 16'd0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, dx,   1'b1, 1'b0, 1'b1, b1,    1'b0, 16'd0, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, dx,   1'b0, 1'b0, 1'b1, b2,    1'b1, 16'd0, 1'b0, 16'd1};
    tbl[10] = '{1'b1, dx,   1'b0, 1'b0, 1'b1, b2,    1'b1, 16'd0, 1'b0, 16'd1};
    tbl[11] = '{1'b0, '0,   1'b1, 1'b1, 1'b1, b2,    1'b1, 16'd0, 1'b0, 16'd1};
    tbl[12] = '{1'b0, '0,   1'b1, 1'b1, 1'b0, 48'h0, 1'b0, 16'd0, 1'b0, 16'd2};

    do_reset();

    // Single matrix, then the same matrix under 1,0,0,1 backpressure.
    for (int i = 0; i < 13; i++) begin
      sv = tbl[i].sv; sd = tbl[i].sd; mr = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_sready", i), 64'(sr1), 64'(tbl[i].sr));
      chk($sformatf("vec%0d_sready3", i), 64'(sr3), 64'(tbl[i].sr));
      chk($sformatf("vec%0d_mvalid", i), 64'(mv1), 64'(tbl[i].mv));
      if (tbl[i].mv) chk($sformatf("vec%0d_mdata", i), 64'(md1), 64'(tbl[i].md));
      chk($sformatf("vec%0d_mlast1", i), 64'(l1), 64'(tbl[i].l1));
      chk($sformatf("vec%0d_matcnt1", i), 64'(mc1), 64'(tbl[i].m1));
      chk($sformatf("vec%0d_mlast3", i), 64'(l3), 64'(tbl[i].l3));
      chk($sformatf("vec%0d_matcnt3", i), 64'(mc3), 64'(tbl[i].m3));
      tick;
    end

    // Upstream starvation: stays idle and ready.
    sv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("starve_sready", 64'(sr1), 64'd1);
      chk("starve_mvalid", 64'(mv1), 64'd0);
      chk("starve_mvalid3", 64'(mv3), 64'd0);
      chk("starve_matcnt3", 64'(mc3), 64'd2);
      tick;
    end

    // Four matrices back to back.
    do_reset();
    stream(4, 16'h2000);

    // Six matrices into 3-matrix packets.
    do_reset();
    lastpos.delete();
    stream(6, 16'h3000);
    chk("pkt3_last_count", 64'(lastpos.size()), 64'd2);
    chk("pkt3_last_pos0", 64'(lastpos.size() > 0 ? lastpos[0] : 0), 64'd9);
    chk("pkt3_last_pos1", 64'(lastpos.size() > 1 ? lastpos[1] : 0), 64'd18);

    // Reset after beat 1 of the second matrix of a packet.
    do_reset();
    stream(1, 16'h4000);
    sv = 1'b1; sd = mkword(16'h5000); mr = 1'b1;
    @(negedge clk);
    chk("abort_accept", 64'(sr3), 64'd1);
    tick;
    sv = 1'b0;
    @(negedge clk);
    chk("abort_beat0", 64'(md3), 64'(beatval(16'h5000, 0)));
    tick;
    @(negedge clk);
    chk("abort_beat1", 64'(md3), 64'(beatval(16'h5000, 1)));
    tick;
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_sready_in_rst", 64'(sr3), 64'd0);
    chk("abort_matcnt_before", 64'(mc3), 64'd1);
    tick;
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_mvalid", 64'(mv3), 64'd0);
    chk("abort_matcnt", 64'(mc3), 64'd0);
    chk("abort_mlast", 64'(l3), 64'd0);
    chk("abort_sready_after", 64'(sr3), 64'd1);
    tick;
    exp_m3 = 0;
    lastpos.delete();
    stream(3, 16'h6000);
    chk("abort_next_last_count", 64'(lastpos.size()), 64'd1);
    chk("abort_next_last_pos", 64'(lastpos.size() > 0 ? lastpos[0] : 0), 64'd9);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
